// File: rtl/adc_scan_sequencer.sv
// Multi-channel scan sequencer for a muxed parallel ADC: select, WR strobe, EOC wait with timeout, RD strobe, capture.
// Optional back-to-back scanning while CONVERT is held high: define CONTINUOUS_SCAN_EN.
module adc_scan_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = 2,
  parameter int unsigned WR_CYCLES = 20,
  parameter int unsigned RD_CYCLES = 4,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CONVERT,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              INTR_N,
  input  logic [DATA_W-1:0] ADC_DATA,
  output logic              WR,
  output logic              RD,
  output logic [CH_W-1:0]   MUX_SEL,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [CH_W-1:0]   CH_OUT,
  output logic              VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic              TO_ERR
);

  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    WR_LOW   = 3'd2,
    WAIT_EOC = 3'd3,
    RD_LOW   = 3'd4,
    CAPTURE  = 3'd5,
    FINISH   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NUM_CH-1:0]   mask_q, mask_d, pend_clr;
  logic [CH_W-1:0]     mux_sel_q, mux_sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CH_W-1:0]     ch_out_q, ch_out_d;
  logic                to_err_q, to_err_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                busy_q, busy_d;
  logic                convert_q;
  logic                intr_s1_q, intr_s2_q;

  // Lowest set bit of a channel mask; the scan order is ascending.
  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // INTR_N synchroniser and CONVERT edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      intr_s1_q <= 1'b1;
      intr_s2_q <= 1'b1;
      convert_q <= 1'b0;
    end else begin
      intr_s1_q <= INTR_N;
      intr_s2_q <= intr_s1_q;
      convert_q <= CONVERT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      mux_sel_q <= '0;
      data_q    <= '0;
      ch_out_q  <= '0;
      to_err_q  <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      wr_q      <= 1'b1;
      rd_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      mux_sel_q <= mux_sel_d;
      data_q    <= data_d;
      ch_out_q  <= ch_out_d;
      to_err_q  <= to_err_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    mux_sel_d = mux_sel_q;
    data_d    = data_q;
    ch_out_d  = ch_out_q;
    to_err_d  = to_err_q;
    done_d    = 1'b0;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    // Remaining channels once the current one is retired.
    pend_clr  = mask_q & ~(NUM_CH'(1) << mux_sel_q);

    case (state_q)
      IDLE: begin
        if (CONVERT && !convert_q) begin
          to_err_d = 1'b0;
          mask_d   = CH_EN;
          cnt_d    = '0;
          if (CH_EN == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = SELECT;
            mux_sel_d = lowest(CH_EN);
          end
        end
      end
      SELECT: begin
        state_d = WR_LOW;
        cnt_d   = '0;
      end
      WR_LOW: begin
        if (cnt_q == WR_LAST) begin
          state_d = WAIT_EOC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_EOC: begin
        if (!intr_s2_q) begin
          state_d = RD_LOW;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          // Abandon this channel without reading it.
          to_err_d = 1'b1;
          mask_d   = pend_clr;
          cnt_d    = '0;
          if (pend_clr != '0) begin
            state_d   = SELECT;
            mux_sel_d = lowest(pend_clr);
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RD_LOW: begin
        if (cnt_q == RD_LAST) begin
          state_d  = CAPTURE;
          data_d   = ADC_DATA;
          ch_out_d = mux_sel_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CAPTURE: begin
        mask_d = pend_clr;
        if (pend_clr != '0) begin
          state_d   = SELECT;
          mux_sel_d = lowest(pend_clr);
        end else begin
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
`ifdef CONTINUOUS_SCAN_EN
        if (CONVERT) begin
          to_err_d = 1'b0;
          mask_d   = CH_EN;
          cnt_d    = '0;
          if (CH_EN != '0) begin
            state_d   = SELECT;
            mux_sel_d = lowest(CH_EN);
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Strobes and flags follow the state being entered, so they line up with it.
    wr_d    = (state_d != WR_LOW);
    rd_d    = (state_d != RD_LOW);
    valid_d = (state_d == CAPTURE);
    busy_d  = (state_d != IDLE);
  end

  assign WR       = wr_q;
  assign RD       = rd_q;
  assign MUX_SEL  = mux_sel_q;
  assign DATA_OUT = data_q;
  assign CH_OUT   = ch_out_q;
  assign VALID    = valid_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign TO_ERR   = to_err_q;

endmodule
